// File: rtl/kgp_pkg.sv
// kgp_pkg: shared definitions for the KGP_RISC run-control monitor.
//   - kgp_state_e   : monitor FSM state encoding (3-bit)
//   - KGP_HALT_WORD : instruction encoding that ends a program (also used by
//                     the core decoder)
//   - kgp_is_busy() : busy decode from a registered state
package kgp_pkg;

    localparam logic [31:0] KGP_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_TMO   = 3'd4
    } kgp_state_e;

    function automatic logic kgp_is_busy(input kgp_state_e st);
        return (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/kgp_sat_counter.sv
// kgp_sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   in  1  clock
//   rst_n in  1  asynchronous active-low reset (count -> 0)
//   clr   in  1  synchronous clear, wins over en
//   en    in  1  count enable
//   cnt   out W  current count (registered)
module kgp_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/kgp_run_monitor.sv
// kgp_run_monitor: run-control / halt monitor beside the KGP_RISC core.
// Detects the halt word on the retire stream, waits DRAIN_CYC cycles so the
// last writeback lands, then captures rout, the halt PC and run statistics.
// A cycle-budget watchdog (MAX_CYC, 0 = off) ends runaway programs.
// Optional build macro KGP_MON_STALL_EN adds STALL_CYC and the `stalled`
// output: a PC retiring STALL_CYC consecutive times is treated as a hang.
// Ports:
//   _clk, _rst        clock, asynchronous active-low reset
//   start, clr        begin monitoring / synchronous return to IDLE
//   instr_valid, currInstr, currPC, rout   core retire stream and result reg
//   busy, done, timeout, result_q, halt_pc, cycle_cnt, instr_cnt   status
//   stalled           (KGP_MON_STALL_EN only) stuck-PC detected
module kgp_run_monitor
    import kgp_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(KGP_HALT_WORD),
    parameter int                 CNT_W     = 32,
    parameter int unsigned        DRAIN_CYC = 2,
    parameter int unsigned        MAX_CYC   = 1_000_000
`ifdef KGP_MON_STALL_EN
    ,
    parameter int unsigned        STALL_CYC = 64
`endif
) (
    input  logic              _clk,
    input  logic              _rst,
    input  logic              start,
    input  logic              clr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] currInstr,
    input  logic [DATA_W-1:0] currPC,
    input  logic [DATA_W-1:0] rout,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] result_q,
    output logic [DATA_W-1:0] halt_pc,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
`ifdef KGP_MON_STALL_EN
    ,
    output logic              stalled
`endif
);

    localparam logic             WDOG_EN   = (MAX_CYC != 32'd0);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYC - 32'd1);

    kgp_state_e        state_q, state_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] halt_pc_q, halt_pc_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic is_halt_s, is_instr_s, in_run_s, launch_s, cnt_clr_s;
    logic wdog_hit_s, stall_hit_s;

    assign is_halt_s  = instr_valid && (currInstr == HALT_WORD);
    assign is_instr_s = instr_valid && (currInstr != HALT_WORD);
    assign in_run_s   = (state_q == ST_RUN);
    assign launch_s   = (state_q == ST_IDLE) && start;
    // clr also covers a start in the same cycle, so counters clear either way.
    assign cnt_clr_s  = clr || launch_s;
    assign wdog_hit_s = WDOG_EN && (cycle_cnt == WDOG_LAST);

    kgp_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (_clk),
        .rst_n (_rst),
        .clr   (cnt_clr_s),
        .en    (in_run_s),
        .cnt   (cycle_cnt)
    );

    kgp_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (_clk),
        .rst_n (_rst),
        .clr   (cnt_clr_s),
        .en    (in_run_s && is_instr_s),
        .cnt   (instr_cnt)
    );

`ifdef KGP_MON_STALL_EN
    logic [DATA_W-1:0] last_pc_q, last_pc_d;
    logic              last_vld_q, last_vld_d;
    logic              stalled_q, stalled_d;
    logic [CNT_W-1:0]  rep_cnt_s;
    logic              same_pc_s;
    logic [CNT_W:0]    run_len_s;

    assign same_pc_s = last_vld_q && (currPC == last_pc_q);
    // rep_cnt_s counts repeats after the first sighting, so the run length
    // including the current instruction is rep_cnt_s + 2 on a repeat.
    assign run_len_s = same_pc_s ? ({1'b0, rep_cnt_s} + (CNT_W+1)'(2))
                                 : (CNT_W+1)'(1);
    assign stall_hit_s = in_run_s && is_instr_s
                         && (run_len_s >= (CNT_W+1)'(STALL_CYC));

    kgp_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (_clk),
        .rst_n (_rst),
        .clr   (cnt_clr_s || (in_run_s && is_instr_s && !same_pc_s)),
        .en    (in_run_s && is_instr_s && same_pc_s),
        .cnt   (rep_cnt_s)
    );

    // Track the PC of the previous non-halt retirement and the sticky flag.
    always_comb begin
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        stalled_d  = stalled_q;
        if (cnt_clr_s) begin
            last_vld_d = 1'b0;
            last_pc_d  = '0;
            stalled_d  = 1'b0;
        end else if (in_run_s && is_instr_s) begin
            last_vld_d = 1'b1;
            last_pc_d  = currPC;
            stalled_d  = stalled_q || stall_hit_s;
        end else begin
            last_pc_d  = last_pc_q;
        end
    end

    // Stall-detector registers.
    always_ff @(posedge _clk or negedge _rst) begin
        if (!_rst) begin
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            stalled_q  <= stalled_d;
        end
    end

    assign stalled = stalled_q;
`else
    assign stall_hit_s = 1'b0;
`endif

    // FSM next state and capture registers; clr overrides everything.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        res_d       = res_q;
        halt_pc_d   = halt_pc_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        if (clr) begin
            state_d     = ST_IDLE;
            drain_cnt_d = 4'd0;
            res_d       = '0;
            halt_pc_d   = '0;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_RUN;
                        res_d     = '0;
                        halt_pc_d = '0;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Halt is checked first so it beats a same-cycle watchdog.
                    if (is_halt_s) begin
                        halt_pc_d   = currPC;
                        drain_cnt_d = 4'(DRAIN_CYC);
                        state_d     = ST_DRAIN;
                    end else if (wdog_hit_s || stall_hit_s) begin
                        timeout_d   = 1'b1;
                        state_d     = ST_TMO;
                    end else begin
                        state_d     = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 4'd0) begin
                        res_d   = rout;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 4'd1;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                ST_TMO:  state_d = ST_TMO;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and capture registers.
    always_ff @(posedge _clk or negedge _rst) begin
        if (!_rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 4'd0;
            res_q       <= '0;
            halt_pc_q   <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            res_q       <= res_d;
            halt_pc_q   <= halt_pc_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy     = kgp_is_busy(state_q);
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign result_q = res_q;
    assign halt_pc  = halt_pc_q;

endmodule

// File: tb/tb_kgp_run_monitor.sv
// Directed bench for kgp_run_monitor. Instance a: DRAIN_CYC=2, MAX_CYC=100.
// Instance b: DRAIN_CYC=0, watchdog disabled. Both see the same stimulus.
module tb_kgp_run_monitor;

    logic        clk;
    logic        rst_n;
    logic        start, clr, instr_valid;
    logic [31:0] instr, pc, rout;

    logic        a_busy, a_done, a_tmo;
    logic [31:0] a_res, a_hpc, a_cyc, a_icnt;
    logic        b_busy, b_done, b_tmo;
    logic [31:0] b_res, b_hpc, b_cyc, b_icnt;
`ifdef KGP_MON_STALL_EN
    logic        a_stalled, b_stalled;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    kgp_run_monitor #(.DRAIN_CYC(2), .MAX_CYC(100)
`ifdef KGP_MON_STALL_EN
        , .STALL_CYC(4)
`endif
    ) u_dut_a (
        ._clk(clk), ._rst(rst_n), .start(start), .clr(clr),
        .instr_valid(instr_valid), .currInstr(instr), .currPC(pc), .rout(rout),
        .busy(a_busy), .done(a_done), .timeout(a_tmo), .result_q(a_res),
        .halt_pc(a_hpc), .cycle_cnt(a_cyc), .instr_cnt(a_icnt)
`ifdef KGP_MON_STALL_EN
        , .stalled(a_stalled)
`endif
    );

    kgp_run_monitor #(.DRAIN_CYC(0), .MAX_CYC(0)
`ifdef KGP_MON_STALL_EN
        , .STALL_CYC(4)
`endif
    ) u_dut_b (
        ._clk(clk), ._rst(rst_n), .start(start), .clr(clr),
        .instr_valid(instr_valid), .currInstr(instr), .currPC(pc), .rout(rout),
        .busy(b_busy), .done(b_done), .timeout(b_tmo), .result_q(b_res),
        .halt_pc(b_hpc), .cycle_cnt(b_cyc), .instr_cnt(b_icnt)
`ifdef KGP_MON_STALL_EN
        , .stalled(b_stalled)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; clr = 1'b0; instr_valid = 1'b0;
        instr = 32'h0000_0000; pc = 32'h0000_0000;
    endtask

    // clr back to IDLE then start; leaves monitor in RUN with cycle_cnt=0.
    task automatic restart();
        idle_inputs();
        clr = 1'b1; tick(); clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rout  = 32'd0;
        rst_n = 1'b0;
        #3;
        check("rst_busy",  a_busy, 64'd0);
        check("rst_done",  a_done, 64'd0);
        check("rst_tmo",   a_tmo,  64'd0);
        check("rst_res",   a_res,  64'd0);
        check("rst_cyc",   a_cyc,  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // --- normal run: 5 instructions, halt at 0x14 with rout=42
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy", a_busy, 64'd1);
        check("start_cyc",  a_cyc,  64'd0);
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1; instr = 32'h0000_0013; pc = 32'(i * 4);
            tick();
        end
        instr = 32'hFFFF_FFFF; pc = 32'h0000_0014; rout = 32'd42;
        tick();
        idle_inputs();
        check("halt_pc",    a_hpc,  64'h14);
        check("halt_icnt",  a_icnt, 64'd5);
        check("halt_cyc",   a_cyc,  64'd6);
        check("drain_busy", a_busy, 64'd1);
        check("drain_done", a_done, 64'd0);
        tick();
        check("d1_done_a",  a_done, 64'd0);
        check("d0_done_b",  b_done, 64'd1);
        check("d0_res_b",   b_res,  64'd42);
        tick();
        check("d2_done_a",  a_done, 64'd0);
        check("d2_cyc_frz", a_cyc,  64'd6);
        tick();
        check("d3_done_a",  a_done, 64'd1);
        check("d3_res_a",   a_res,  64'd42);
        check("d3_busy_a",  a_busy, 64'd0);
        check("d3_tmo_a",   a_tmo,  64'd0);
        check("d3_icnt_a",  a_icnt, 64'd5);

        // start ignored in DONE
        start = 1'b1; tick(); start = 1'b0;
        check("done_start_ign", a_done, 64'd1);
        check("done_start_bsy", a_busy, 64'd0);

        // clr + start together in DONE -> IDLE, all zero
        clr = 1'b1; start = 1'b1; tick(); idle_inputs();
        check("clr_busy", a_busy, 64'd0);
        check("clr_done", a_done, 64'd0);
        check("clr_res",  a_res,  64'd0);
        check("clr_hpc",  a_hpc,  64'd0);
        check("clr_icnt", a_icnt, 64'd0);
        check("clr_cyc",  a_cyc,  64'd0);
        tick();
        check("clr_stays_idle", a_busy, 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("lone_start_run", a_busy, 64'd1);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("run_start_ign", a_cyc, 64'd2);

        // --- watchdog: no halt, timeout when cycle_cnt hits 99
        restart();
        repeat (99) tick();
        check("wd_pre_tmo",  a_tmo,  64'd0);
        check("wd_pre_busy", a_busy, 64'd1);
        check("wd_pre_cyc",  a_cyc,  64'd99);
        tick();
        check("wd_tmo",    a_tmo,  64'd1);
        check("wd_busy",   a_busy, 64'd0);
        check("wd_done",   a_done, 64'd0);
        check("wd_res",    a_res,  64'd0);
        check("wd_cyc",    a_cyc,  64'd100);
        check("wd_off_b",  b_tmo,  64'd0);
        check("wd_off_bb", b_busy, 64'd1);

        // --- halt on the watchdog's last cycle: halt wins
        restart();
        repeat (99) tick();
        instr_valid = 1'b1; instr = 32'hFFFF_FFFF; pc = 32'h0000_0040; rout = 32'd7;
        tick();
        idle_inputs();
        check("race_tmo0", a_tmo,  64'd0);
        check("race_busy", a_busy, 64'd1);
        check("race_hpc",  a_hpc,  64'h40);
        repeat (3) tick();
        check("race_done", a_done, 64'd1);
        check("race_tmo",  a_tmo,  64'd0);
        check("race_res",  a_res,  64'd7);

        // --- async reset during DRAIN, then a clean run
        restart();
        instr_valid = 1'b1; instr = 32'h0000_0013; pc = 32'h0000_0000; tick();
        instr = 32'hFFFF_FFFF; pc = 32'h0000_0004; rout = 32'd99; tick();
        idle_inputs();
        check("pre_rst_busy", a_busy, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", a_busy, 64'd0);
        check("arst_hpc",  a_hpc,  64'd0);
        check("arst_icnt", a_icnt, 64'd0);
        check("arst_cyc",  a_cyc,  64'd0);
        check("arst_done", a_done, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("rerun_busy", a_busy, 64'd1);
        check("rerun_cyc",  a_cyc,  64'd0);
        instr_valid = 1'b1; instr = 32'h0000_0013; pc = 32'h0000_0000; tick();
        idle_inputs();
        check("rerun_icnt", a_icnt, 64'd1);
        check("rerun_cyc1", a_cyc,  64'd1);
        repeat (4) tick();
        check("rerun_nodone", a_done, 64'd0);

`ifdef KGP_MON_STALL_EN
        // --- stuck PC: four valid retirements at 0x8
        restart();
        instr_valid = 1'b1; instr = 32'h0000_0013; pc = 32'h0000_0008;
        repeat (3) tick();
        check("stall_pre",     a_stalled, 64'd0);
        check("stall_pre_bsy", a_busy,    64'd1);
        tick();
        idle_inputs();
        check("stall_flag", a_stalled, 64'd1);
        check("stall_tmo",  a_tmo,     64'd1);
        check("stall_busy", a_busy,    64'd0);
        check("stall_done", a_done,    64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
